// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface seq_divider_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16
);
  logic                 start;
  logic [OUT_WIDTH-1:0] dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [OUT_WIDTH-1:0] quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: OUT_WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit
// per clock, with registered busy/done and results held until the next finishing edge.
module seq_divider #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);
  localparam int CNT_W = $clog2(OUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(OUT_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]     dsr_q, dsr_d;
  logic [WIDTH-1:0]     prem_q, prem_d;
  logic [OUT_WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     step_rem;
  logic [OUT_WIDTH-1:0] step_dvd;

  // One restoring step. The working dividend shifts out its MSB into the partial remainder
  // and takes the new quotient bit in at its LSB, so after OUT_WIDTH steps it holds the quotient.
  // The trial difference's top bit is the borrow: partial < 2*divisor keeps it exact.
  function automatic logic [WIDTH+OUT_WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0]     rem,
    input logic [OUT_WIDTH-1:0] dvd,
    input logic [WIDTH-1:0]     dsr
  );
    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;
    logic           ge;
    part = {rem, dvd[OUT_WIDTH-1]};
    diff = part - {1'b0, dsr};
    ge   = ~diff[WIDTH];
    return {(ge ? diff[WIDTH-1:0] : part[WIDTH-1:0]), dvd[OUT_WIDTH-2:0], ge};
  endfunction

  always_comb begin
    {step_rem, step_dvd} = restore_step(prem_q, dvd_q, dsr_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dsr_d  = bus.divisor;
          prem_d = '0;
          cnt_d  = CNT_LOAD;
          if (bus.divisor == '0) begin
            // Zero divisor finishes immediately with a saturated quotient.
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        dvd_d  = step_dvd;
        prem_d = step_rem;
        cnt_d  = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          quo_d   = step_dvd;
          rem_d   = step_rem;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against plain integer division.
module tb_seq_divider;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  seq_divider_if #(.WIDTH(8), .OUT_WIDTH(16)) bus ();

  seq_divider #(.WIDTH(8), .OUT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat counts cycles after the accept edge.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  // Reference: integer division; zero divisor saturates and finishes immediately.
  task automatic check_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input int lat);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          el;
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = 8'd0; ez = 1'b1; el = 0;
    end else begin
      eq = a / b; er = 8'(a % b); ez = 1'b0; el = 16;
    end
    check({tag, ":lat"}, lat, el);
    check({tag, ":done"}, {31'd0, bus.done}, 32'd1);
    check({tag, ":quo"}, {16'd0, bus.quotient}, {16'd0, eq});
    check({tag, ":rem"}, {24'd0, bus.remainder}, {24'd0, er});
    check({tag, ":dbz"}, {31'd0, bus.div_by_zero}, {31'd0, ez});
    step();
    check({tag, ":pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic        saw_done;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    step();
    step();
    reset = 1'b0;
    check("rst:busy", {31'd0, bus.busy}, 32'd0);
    check("rst:done", {31'd0, bus.done}, 32'd0);
    check("rst:quo", {16'd0, bus.quotient}, 32'd0);
    check("rst:rem", {24'd0, bus.remainder}, 32'd0);
    check("rst:dbz", {31'd0, bus.div_by_zero}, 32'd0);
    step();

    do_op(16'd1000, 8'd7, lat);
    check("d1000:quo142", {16'd0, bus.quotient}, 32'd142);
    check_op("d1000", 16'd1000, 8'd7, lat);
    do_op(16'd65535, 8'd255, lat);
    check_op("d65535", 16'd65535, 8'd255, lat);
    do_op(16'd5, 8'd10, lat);
    check_op("d5", 16'd5, 8'd10, lat);
    a = 16'(200 * 13 + 12);
    do_op(a, 8'd13, lat);
    check("rt:quo200", {16'd0, bus.quotient}, 32'd200);
    check_op("roundtrip", a, 8'd13, lat);
    do_op(16'd1234, 8'd0, lat);
    check_op("divzero", 16'd1234, 8'd0, lat);

    // Starts while busy are ignored; old results hold through the run.
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    step();
    check("ign:busy", {31'd0, bus.busy}, 32'd1);
    check("ign:hold", {16'd0, bus.quotient}, 32'hFFFF);
    lat = 0;
    while (!bus.done && lat < 40) begin
      if (lat == 3 || lat == 10) begin
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 8'd3;
      end else begin
        bus.start = 1'b0;
      end
      step();
      lat++;
    end
    bus.start = 1'b0;
    check_op("ignored", 16'd1000, 8'd7, lat);
    do_op(16'd9, 8'd3, lat);
    check_op("d9", 16'd9, 8'd3, lat);

    // Back-to-back with start held high: DONE ignores it, IDLE accepts next cycle.
    bus.dividend = 16'd4321;
    bus.divisor  = 8'd17;
    bus.start    = 1'b1;
    step();
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check_op("b2b1", 16'd4321, 8'd17, lat);
    bus.dividend = 16'd60000;
    bus.divisor  = 8'd251;
    step();
    check("b2b:accept", {31'd0, bus.busy}, 32'd1);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check_op("b2b2", 16'd60000, 8'd251, lat);

    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 5 == 4) a = 16'($urandom_range(0, 300));
      do_op(a, b, lat);
      check_op("rand", a, b, lat);
    end

    // Reset mid-run clears everything and suppresses the pending done.
    do_op(16'd1000, 8'd7, lat);
    check_op("pre_rst", 16'd1000, 8'd7, lat);
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst:busy", {31'd0, bus.busy}, 32'd0);
    check("mrst:done", {31'd0, bus.done}, 32'd0);
    check("mrst:quo", {16'd0, bus.quotient}, 32'd0);
    check("mrst:rem", {24'd0, bus.remainder}, 32'd0);
    check("mrst:dbz", {31'd0, bus.div_by_zero}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      saw_done = saw_done | bus.done | bus.busy;
    end
    check("mrst:nodone", {31'd0, saw_done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
